uarttx: RTL

UARTTX -- requirements
Module: uarttx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 34 +++
 rtl/uarttx.sv | 101 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART line constants and state enumeration
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int   DEFAULT_CLKS_PER_BIT = 16;
  localparam int   DATA_BITS            = 8;
  localparam logic LINE_IDLE            = 1'b1;
  localparam logic LINE_START           = 1'b0;

  // Cycles from the accepting edge to the end-of-frame edge.
  function automatic int frame_cycles(input int clks_per_bit, input int stop_bits);
    return (DATA_BITS + 1 + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit cycle counter with clear and bit_end strobe
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int              CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end_o = (cnt_q == LAST);

  // Restart at every bit boundary so the count never wraps inside a bit.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uarttx.sv
// rtl/uarttx.sv - 8N1/8N2 UART transmitter with registered line and status outputs
module uarttx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           idx_q;
  logic                 txd_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 bit_end;

  // Held clear throughout IDLE, which also covers the accepting edge.
  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == IDLE),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      txd_q   <= LINE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          txd_q <= LINE_IDLE;
          idx_q <= '0;
          if (tx_start) begin
            shift_q <= tx_data;
            state_q <= START;
            txd_q   <= LINE_START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            txd_q   <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx_q == LAST_DATA) begin
              state_q <= STOP;
              txd_q   <= LINE_IDLE;
              idx_q   <= '0;
            end else begin
              txd_q <= shift_q[idx_q + 3'd1];
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          // idx_q is reused to count stop bits.
          if (bit_end) begin
            if (idx_q == LAST_STOP) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign txd     = txd_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
